// File: rtl/life_frame_sched.sv
// ---------------------------------------------------------------------------
// life_frame_sched
//
// Generation scheduler between the VGA scan-out timing and the life
// evolution engine. It paces generations in frames, fires a one-cycle start
// pulse at the engine, waits for the engine to report completion, and then
// flips the display/work buffer select at the next start of vertical sync,
// so scan-out never shows a half-written generation.
//
// Optional feature: define VIEW_LATCH_EN to add frame-latched view registers
// (shift_x, shift_y, scroll). They load from their *_in inputs only on a
// frame tick, so pan/zoom changes never tear mid-frame. Without the macro
// those ports do not exist.
//
// Ports:
//   clk            system/pixel clock
//   rst_n          asynchronous active-low reset
//   vsync          vertical sync from scan-out timing (active level = VSPP)
//   run            level, 1 = free-running evolution
//   step_req       one-cycle pulse, request exactly one generation
//   setting_status manual edit mode active, blocks new generations
//   period         frames per generation (0 behaves as 1)
//   engine_start   one-cycle pulse, engine begins a generation
//   engine_done    one-cycle pulse from engine, generation written
//   buf_sel        buffer read by scan-out; engine writes !buf_sel
//   gen_count      completed generations, wraps
//   busy           1 while a generation is starting, running or awaiting swap
//   overrun        sticky, a generation missed its frame slot
//   clr_overrun    pulse, clears overrun (a coincident set wins)
//   dbg_state      current scheduler state, for observation only
//
// Handshake: engine_start is a single-cycle pulse that hands the work buffer
// to the engine; the engine owns it until it returns a single-cycle
// engine_done. engine_done seen outside the running state is ignored.
// ---------------------------------------------------------------------------
module life_frame_sched #(
    parameter bit VSPP     = 1'b1,
    parameter int PERIOD_W = 8,
    parameter int GEN_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                run,
    input  logic                step_req,
    input  logic                setting_status,
    input  logic [PERIOD_W-1:0] period,
    output logic                engine_start,
    input  logic                engine_done,
    output logic                buf_sel,
    output logic [GEN_W-1:0]    gen_count,
    output logic                busy,
    output logic                overrun,
    input  logic                clr_overrun,
`ifdef VIEW_LATCH_EN
    input  logic [15:0]         shift_x_in,
    input  logic [15:0]         shift_y_in,
    input  logic [3:0]          scroll_in,
    output logic [15:0]         shift_x,
    output logic [15:0]         shift_y,
    output logic [3:0]          scroll,
`endif
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_BUSY      = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic                frame_tick_q;
    logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                step_pend_q, step_pend_d;
    logic                buf_sel_q, buf_sel_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic                overrun_q, overrun_d;

    logic [PERIOD_W-1:0] eff_period;
    logic                start_entry;
    logic                swap_now;
    logic                overrun_set;

    assign eff_period = (period == '0) ? PERIOD_W'(1) : period;

    // Vsync leading-edge detect. The tick is registered, so it appears one
    // cycle after vsync is first sampled at its active level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= ~VSPP;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            frame_tick_q <= (vsync == VSPP) && (vsync_q != VSPP);
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_d      = state_q;
        start_entry  = 1'b0;
        swap_now     = 1'b0;
        engine_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!setting_status &&
                    (step_pend_q || (run && (frame_cnt_q >= eff_period)))) begin
                    state_d     = ST_START;
                    start_entry = 1'b1;
                end
            end
            ST_START: begin
                engine_start = 1'b1;
                state_d      = ST_BUSY;
            end
            ST_BUSY: begin
                // Edit mode does not abort a running generation.
                if (engine_done) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                // A tick in the same cycle as engine_done was consumed while
                // still in BUSY; the swap waits for the following tick.
                if (frame_tick_q) begin
                    swap_now = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overrun compares the frame count before this tick's increment: the
    // slot is missed only if more whole frames than the period have elapsed.
    assign overrun_set = swap_now && (frame_cnt_q > eff_period);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (start_entry) begin
            frame_cnt_d = '0;
        end else if (frame_tick_q && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        // A request arriving in the launch cycle is kept, so it produces one
        // more generation instead of being lost.
        step_pend_d = (step_pend_q && !start_entry) || step_req;

        buf_sel_d   = swap_now ? ~buf_sel_q : buf_sel_q;
        gen_count_d = swap_now ? gen_count_q + 1'b1 : gen_count_q;
        overrun_d   = overrun_set || (overrun_q && !clr_overrun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            step_pend_q <= 1'b0;
            buf_sel_q   <= 1'b0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            step_pend_q <= step_pend_d;
            buf_sel_q   <= buf_sel_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign buf_sel   = buf_sel_q;
    assign gen_count = gen_count_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

`ifdef VIEW_LATCH_EN
    logic [15:0] shift_x_q;
    logic [15:0] shift_y_q;
    logic [3:0]  scroll_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_x_q <= '0;
            shift_y_q <= '0;
            scroll_q  <= '0;
        end else if (frame_tick_q) begin
            shift_x_q <= shift_x_in;
            shift_y_q <= shift_y_in;
            scroll_q  <= scroll_in;
        end
    end

    assign shift_x = shift_x_q;
    assign shift_y = shift_y_q;
    assign scroll  = scroll_q;
`endif

endmodule

// File: tb/tb_life_frame_sched.sv
module tb_life_frame_sched;

    localparam bit VSPP = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        setting_status = 1'b0;
    logic [7:0]  period = 8'd2;
    logic        engine_start;
    logic        engine_done = 1'b0;
    logic        buf_sel;
    logic [31:0] gen_count;
    logic        busy;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic [1:0]  dbg_state;
`ifdef VIEW_LATCH_EN
    logic [15:0] shift_x_in = 16'h0;
    logic [15:0] shift_y_in = 16'h0;
    logic [3:0]  scroll_in = 4'h0;
    logic [15:0] shift_x;
    logic [15:0] shift_y;
    logic [3:0]  scroll;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    life_frame_sched #(.VSPP(VSPP), .PERIOD_W(8), .GEN_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vsync(vsync),
        .run(run),
        .step_req(step_req),
        .setting_status(setting_status),
        .period(period),
        .engine_start(engine_start),
        .engine_done(engine_done),
        .buf_sel(buf_sel),
        .gen_count(gen_count),
        .busy(busy),
        .overrun(overrun),
        .clr_overrun(clr_overrun),
`ifdef VIEW_LATCH_EN
        .shift_x_in(shift_x_in),
        .shift_y_in(shift_y_in),
        .scroll_in(scroll_in),
        .shift_x(shift_x),
        .shift_y(shift_y),
        .scroll(scroll),
`endif
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: tracks what the scheduler is doing as a set of
    // activity flags (launching / computing / awaiting swap) plus counts.
    // ------------------------------------------------------------------
    bit          m_vs_prev = !VSPP;
    bit          m_tick = 1'b0;
    int          m_frames = 0;
    bit          m_pend = 1'b0;
    bit          m_launching = 1'b0;
    bit          m_computing = 1'b0;
    bit          m_await_swap = 1'b0;
    bit          m_buf = 1'b0;
    logic [31:0] m_gen = 32'd0;
    bit          m_ovr = 1'b0;
    logic [15:0] m_sx = 16'h0;
    logic [15:0] m_sy = 16'h0;
    logic [3:0]  m_sc = 4'h0;

    always @(posedge clk or negedge rst_n) begin : model
        int eff;
        bit idle, launch, swap, ovr_set, fin;
        if (!rst_n) begin
            m_vs_prev = !VSPP;
            m_tick = 1'b0;
            m_frames = 0;
            m_pend = 1'b0;
            m_launching = 1'b0;
            m_computing = 1'b0;
            m_await_swap = 1'b0;
            m_buf = 1'b0;
            m_gen = 32'd0;
            m_ovr = 1'b0;
            m_sx = 16'h0;
            m_sy = 16'h0;
            m_sc = 4'h0;
        end else begin
            eff = (period == 8'd0) ? 1 : int'(period);
            idle = !m_launching && !m_computing && !m_await_swap;
            launch = idle && !setting_status && (m_pend || (run && m_frames >= eff));
            swap = m_await_swap && m_tick;
            ovr_set = swap && (m_frames > eff);
            fin = m_computing && engine_done;
            if (swap) begin
                m_buf = !m_buf;
                m_gen = m_gen + 32'd1;
            end
            m_await_swap = (m_await_swap && !m_tick) || fin;
            m_computing = m_launching || (m_computing && !engine_done);
            m_launching = launch;
            if (launch) m_frames = 0;
            else if (m_tick && m_frames < 255) m_frames = m_frames + 1;
            m_pend = (m_pend && !launch) || step_req;
            m_ovr = ovr_set || (m_ovr && !clr_overrun);
`ifdef VIEW_LATCH_EN
            if (m_tick) begin
                m_sx = shift_x_in;
                m_sy = shift_y_in;
                m_sc = scroll_in;
            end
`endif
            m_tick = (vsync == VSPP) && (m_vs_prev != VSPP);
            m_vs_prev = vsync;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        check("engine_start", {31'd0, engine_start}, {31'd0, m_launching});
        check("busy", {31'd0, busy}, {31'd0, (m_launching || m_computing || m_await_swap)});
        check("buf_sel", {31'd0, buf_sel}, {31'd0, m_buf});
        check("gen_count", gen_count, m_gen);
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef VIEW_LATCH_EN
        check("shift_x", {16'd0, shift_x}, {16'd0, m_sx});
        check("shift_y", {16'd0, shift_y}, {16'd0, m_sy});
        check("scroll", {28'd0, scroll}, {28'd0, m_sc});
`endif
        if (engine_start === 1'b1) start_cnt++;
    end

    // ------------------------------------------------------------------
    // Driver tasks: all return 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns in the cycle where the registered frame tick is high.
    task automatic vs_tick();
        vsync = VSPP;
        cyc(1);
        vsync = !VSPP;
    endtask

    task automatic pulse_done();
        engine_done = 1'b1;
        cyc(1);
        engine_done = 1'b0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
    endtask

    initial begin : stim
        int s0;
        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", {31'd0, engine_start}, 32'd0);
        check("rst_buf", {31'd0, buf_sel}, 32'd0);
        check("rst_gen", gen_count, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        run = 1'b1;
        period = 8'd2;

        // free run, period 2, done 5 cycles after start
        vs_tick();
        cyc(5);
        vs_tick();
        check("t1_no_start_tick", {31'd0, engine_start}, 32'd0);
        cyc(1);
        check("t1_no_start_early", {31'd0, engine_start}, 32'd0);
        cyc(1);
        check("t1_start", {31'd0, engine_start}, 32'd1);
        cyc(4);
        pulse_done();
        check("t1_buf_hold", {31'd0, buf_sel}, 32'd0);
        check("t1_busy_swap", {31'd0, busy}, 32'd1);
        vs_tick();
        cyc(1);
        check("t1_buf_swap", {31'd0, buf_sel}, 32'd1);
        check("t1_gen1", gen_count, 32'd1);
        cyc(3);
        check("t1_idle_start", {31'd0, engine_start}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        vs_tick();
        cyc(2);
        check("t1_start2", {31'd0, engine_start}, 32'd1);
        run = 1'b0;
        cyc(4);
        pulse_done();
        vs_tick();
        cyc(1);
        check("t1_gen2", gen_count, 32'd2);

        // single step with two extra requests in BUSY
        cyc(3);
        pulse_step();
        cyc(1);
        check("t2_start", {31'd0, engine_start}, 32'd1);
        cyc(1);
        pulse_step();
        cyc(1);
        pulse_step();
        pulse_done();
        vs_tick();
        cyc(1);
        check("t2_gen3", gen_count, 32'd3);
        cyc(1);
        check("t2_pending_start", {31'd0, engine_start}, 32'd1);
        cyc(1);
        pulse_done();
        vs_tick();
        cyc(1);
        check("t2_gen4", gen_count, 32'd4);
        cyc(5);
        check("t2_no_more", {31'd0, busy}, 32'd0);

        // edit lockout
        setting_status = 1'b1;
        run = 1'b1;
        period = 8'd1;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            vs_tick();
            cyc(3);
        end
        check("t3_locked_starts", start_cnt - s0, 32'd0);
        setting_status = 1'b0;
        cyc(1);
        check("t3_release_start", {31'd0, engine_start}, 32'd1);
        cyc(1);
        run = 1'b0;
        pulse_done();
        vs_tick();
        cyc(1);
        check("t3_gen5", gen_count, 32'd5);

        // overrun
        run = 1'b1;
        cyc(1);
        check("t4_start", {31'd0, engine_start}, 32'd1);
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            vs_tick();
            cyc(2);
        end
        pulse_done();
        vs_tick();
        cyc(1);
        run = 1'b0;
        check("t4_ovr_set", {31'd0, overrun}, 32'd1);
        check("t4_gen6", gen_count, 32'd6);
        pulse_clr();
        check("t4_ovr_clr", {31'd0, overrun}, 32'd0);
        pulse_step();
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            vs_tick();
            cyc(1);
        end
        pulse_done();
        vsync = VSPP;
        cyc(1);
        clr_overrun = 1'b1;
        vsync = !VSPP;
        cyc(1);
        clr_overrun = 1'b0;
        check("t4_set_beats_clr", {31'd0, overrun}, 32'd1);
        check("t4_gen7", gen_count, 32'd7);

        // engine_done coincident with frame tick
        pulse_step();
        cyc(2);
        vsync = VSPP;
        cyc(1);
        engine_done = 1'b1;
        vsync = !VSPP;
        cyc(1);
        engine_done = 1'b0;
        check("t5_no_swap", {31'd0, buf_sel}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd1);
        cyc(3);
        vs_tick();
        cyc(1);
        check("t5_swap_later", {31'd0, buf_sel}, 32'd0);
        check("t5_gen8", gen_count, 32'd8);

        // async reset in BUSY with buf_sel = 1
        pulse_step();
        cyc(2);
        pulse_done();
        vs_tick();
        cyc(1);
        pulse_step();
        cyc(2);
        check("t6_pre_busy", {31'd0, busy}, 32'd1);
        check("t6_pre_buf", {31'd0, buf_sel}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_buf", {31'd0, buf_sel}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_async_gen", gen_count, 32'd0);
        check("t6_async_ovr", {31'd0, overrun}, 32'd0);
        check("t6_async_start", {31'd0, engine_start}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // period 0 behaves as 1; view latch loads only on a tick
        period = 8'd0;
        run = 1'b1;
`ifdef VIEW_LATCH_EN
        shift_x_in = 16'h1234;
        shift_y_in = 16'hbeef;
        scroll_in = 4'h9;
`endif
        cyc(3);
        check("t7_p0_wait", {31'd0, busy}, 32'd0);
`ifdef VIEW_LATCH_EN
        check("t7_view_hold", {16'd0, shift_x}, 32'h0);
`endif
        vs_tick();
        cyc(1);
`ifdef VIEW_LATCH_EN
        check("t7_view_load_x", {16'd0, shift_x}, 32'h1234);
        check("t7_view_load_sc", {28'd0, scroll}, 32'h9);
`endif
        cyc(1);
        check("t7_p0_start", {31'd0, engine_start}, 32'd1);
        run = 1'b0;
        cyc(1);
        pulse_done();
        vs_tick();
        cyc(1);
        check("t7_gen1", gen_count, 32'd1);
        check("t7_buf1", {31'd0, buf_sel}, 32'd1);
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
